gshare_pht_ctrl: RTL and testbench

Controller for the gshare branch predictor. It owns the speculative global history register and a 2^GHR_W-entry table of 2-bit saturating counters, and shares the table's single access port between fetch-side predict lookups and execute-side resolution updates. Updates are queued in a small FIFO and applied by read-modify-write. History is restored from a pipeline-carried checkpoint on mispredict.

---
 rtl/gshare_pht_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_gshare_pht_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/gshare_pht_ctrl.sv
// gshare_pht_ctrl
// Owns the speculative global history register (GHR) and a 2^GHR_W-entry
// table of 2-bit saturating counters. The table has a single access port
// shared between fetch-side lookups and execute-side resolution updates.
// Resolutions are queued in a small FIFO and applied by read-modify-write.
// On a mispredict the history is rebuilt from the checkpoint carried with
// the branch.
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_pred_req/i_pred_pc  lookup request and low PC bits
//   o_pred_gnt            lookup accepted this cycle (combinational)
//   o_pred_valid/taken/index/ghr  registered lookup result, one cycle later
//   i_res_*               branch resolution (outcome, index, checkpoint)
//   o_res_ready           update FIFO not full (combinational)
//   o_ghr_out             current speculative history
module gshare_pht_ctrl #(
  parameter int GHR_W      = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_LIM = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_pred_req,
  input  logic [GHR_W-1:0] i_pred_pc,
  output logic             o_pred_gnt,
  output logic             o_pred_valid,
  output logic             o_pred_taken,
  output logic [GHR_W-1:0] o_pred_index,
  output logic [GHR_W-1:0] o_pred_ghr,
  input  logic             i_res_valid,
  input  logic             i_res_taken,
  input  logic [GHR_W-1:0] i_res_index,
  input  logic [GHR_W-1:0] i_res_ghr,
  input  logic             i_res_mispredict,
  output logic             o_res_ready,
  output logic [GHR_W-1:0] o_ghr_out
);

  localparam int ENTRIES = 1 << GHR_W;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int SC_W    = $clog2(STARVE_LIM + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPD_RD = 2'd1,
    UPD_WR = 2'd2
  } state_t;

  function automatic logic [1:0] sat_upd(input logic [1:0] c, input logic t);
    if (t) return (c == 2'd3) ? 2'd3 : c + 2'd1;
    else   return (c == 2'd0) ? 2'd0 : c - 2'd1;
  endfunction

  // Newest outcome enters at the MSB.
  function automatic logic [GHR_W-1:0] ghr_shift(input logic [GHR_W-1:0] h,
                                                 input logic t);
    return {t, h[GHR_W-1:1]};
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_pht [ENTRIES];
  logic [1:0]       r_hold;
  logic [GHR_W-1:0] r_fifo_idx [FIFO_DEPTH];
  logic             r_fifo_tkn [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [SC_W-1:0]  r_starve;
  logic [GHR_W-1:0] r_ghr;
  logic             r_pred_valid;
  logic             r_pred_taken;
  logic [GHR_W-1:0] r_pred_index;
  logic [GHR_W-1:0] r_pred_ghr;

  logic             w_flush;
  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic             w_gnt;
  logic             w_upd_start;
  logic [GHR_W-1:0] w_pred_idx;
  logic             w_pred_bit;
  logic [GHR_W-1:0] w_head_idx;
  logic             w_head_tkn;

  assign w_flush    = i_res_valid & i_res_mispredict;
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
  // Ready is a pure function of the count so execute never sees a
  // combinational path from the port FSM.
  assign w_push     = i_res_valid & ~w_full;
  assign w_pop      = (r_state == UPD_WR);
  assign w_pred_idx = i_pred_pc ^ r_ghr;
  assign w_pred_bit = r_pht[w_pred_idx][1];
  assign w_head_idx = r_fifo_idx[r_rd_ptr];
  assign w_head_tkn = r_fifo_tkn[r_rd_ptr];

  // Port arbitration: one table access per cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt       = 1'b0;
    w_upd_start = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_flush) begin
          if (!w_empty && (w_full || !i_pred_req ||
                           r_starve == SC_W'(STARVE_LIM))) begin
            w_state_nxt = UPD_RD;
            w_upd_start = 1'b1;
          end else if (i_pred_req) begin
            w_gnt = 1'b1;
          end
        end
      end
      UPD_RD:  w_state_nxt = UPD_WR;
      UPD_WR:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_starve <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_upd_start || w_empty)
        r_starve <= '0;
      else if (w_gnt && r_starve != SC_W'(STARVE_LIM))
        r_starve <= r_starve + SC_W'(1);
    end
  end

  // Queue storage carries no reset; occupancy is tracked by r_count.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo_idx[r_wr_ptr] <= i_res_index;
      r_fifo_tkn[r_wr_ptr] <= i_res_taken;
    end
  end

  // Table port: lookup read is combinational; update is read then write.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < ENTRIES; i++) r_pht[i] <= 2'b01;
      r_hold <= 2'b01;
    end else if (r_state == UPD_RD) begin
      r_hold <= r_pht[w_head_idx];
    end else if (r_state == UPD_WR) begin
      r_pht[w_head_idx] <= sat_upd(r_hold, w_head_tkn);
    end
  end

  // Lookup result stage and speculative history.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ghr        <= '0;
      r_pred_valid <= 1'b0;
      r_pred_taken <= 1'b0;
      r_pred_index <= '0;
      r_pred_ghr   <= '0;
    end else begin
      r_pred_valid <= w_gnt;
      if (w_gnt) begin
        r_pred_taken <= w_pred_bit;
        r_pred_index <= w_pred_idx;
        r_pred_ghr   <= r_ghr;
      end
      if (w_flush)
        r_ghr <= ghr_shift(i_res_ghr, i_res_taken);
      else if (w_gnt)
        r_ghr <= ghr_shift(r_ghr, w_pred_bit);
    end
  end

  assign o_pred_gnt   = w_gnt;
  assign o_pred_valid = r_pred_valid;
  assign o_pred_taken = r_pred_taken;
  assign o_pred_index = r_pred_index;
  assign o_pred_ghr   = r_pred_ghr;
  assign o_res_ready  = ~w_full;
  assign o_ghr_out    = r_ghr;

endmodule

// File: tb/tb_gshare_pht_ctrl.sv
// Directed bench for gshare_pht_ctrl (GHR_W=3, FIFO_DEPTH=4, STARVE_LIM=4).
module tb_gshare_pht_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pred_req;
  logic [2:0] pred_pc;
  logic       pred_gnt;
  logic       pred_valid;
  logic       pred_taken;
  logic [2:0] pred_index;
  logic [2:0] pred_ghr;
  logic       res_valid;
  logic       res_taken;
  logic [2:0] res_index;
  logic [2:0] res_ghr;
  logic       res_mispredict;
  logic       res_ready;
  logic [2:0] ghr_out;

  int n_tests = 0;
  int n_fail  = 0;

  gshare_pht_ctrl #(.GHR_W(3), .FIFO_DEPTH(4), .STARVE_LIM(4)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_pred_req      (pred_req),
    .i_pred_pc       (pred_pc),
    .o_pred_gnt      (pred_gnt),
    .o_pred_valid    (pred_valid),
    .o_pred_taken    (pred_taken),
    .o_pred_index    (pred_index),
    .o_pred_ghr      (pred_ghr),
    .i_res_valid     (res_valid),
    .i_res_taken     (res_taken),
    .i_res_index     (res_index),
    .i_res_ghr       (res_ghr),
    .i_res_mispredict(res_mispredict),
    .o_res_ready     (res_ready),
    .o_ghr_out       (ghr_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One resolution with no lookups: IDLE decides, then RD, then WR.
  task automatic train(input logic [2:0] idx, input logic tkn,
                       input logic [1:0] old_c, input logic [1:0] new_c);
    res_valid = 1'b1; res_index = idx; res_taken = tkn; res_mispredict = 1'b0;
    tick;
    res_valid = 1'b0;
    chk("train_cnt1", 32'(dut.r_count), 32'd1);
    chk("train_idle", 32'(dut.r_state), 32'd0);
    tick;
    chk("train_rd", 32'(dut.r_state), 32'd1);
    tick;
    chk("train_wr", 32'(dut.r_state), 32'd2);
    chk("train_old", 32'(dut.r_pht[idx]), 32'(old_c));
    tick;
    chk("train_new", 32'(dut.r_pht[idx]), 32'(new_c));
    chk("train_cnt0", 32'(dut.r_count), 32'd0);
    chk("train_back", 32'(dut.r_state), 32'd0);
  endtask

  logic [2:0] ff_idx [5] = '{3'd1, 3'd1, 3'd3, 3'd4, 3'd1};
  logic       ff_tkn [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  logic       ff_gnt [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  logic       ff_rdy [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  logic       sv_gnt [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [1:0] sv_st  [8] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd0};

  initial begin
    rst_n = 1'b0; pred_req = 1'b0; pred_pc = '0;
    res_valid = 1'b0; res_taken = 1'b0; res_index = '0; res_ghr = '0;
    res_mispredict = 1'b0;
    tick; tick;
    chk("rst_ghr", 32'(ghr_out), 32'd0);
    chk("rst_pvalid", 32'(pred_valid), 32'd0);
    chk("rst_ready", 32'(res_ready), 32'd1);
    chk("rst_pht0", 32'(dut.r_pht[0]), 32'd1);
    rst_n = 1'b1;
    tick;

    // Reset lookups: all counters weakly not-taken, history stays zero.
    for (int k = 0; k < 8; k++) begin
      pred_req = 1'b1; pred_pc = 3'(k);
      #1;
      chk("lk_gnt", 32'(pred_gnt), 32'd1);
      tick;
      chk("lk_valid", 32'(pred_valid), 32'd1);
      chk("lk_taken", 32'(pred_taken), 32'd0);
      chk("lk_index", 32'(pred_index), 32'(k));
      chk("lk_pghr", 32'(pred_ghr), 32'd0);
      chk("lk_ghr", 32'(ghr_out), 32'd0);
    end
    pred_req = 1'b0;
    tick;
    chk("lk_pulse", 32'(pred_valid), 32'd0);

    // Training index 5: 1 -> 2 -> 3 -> 3.
    train(3'd5, 1'b1, 2'd1, 2'd2);
    train(3'd5, 1'b1, 2'd2, 2'd3);
    train(3'd5, 1'b1, 2'd3, 2'd3);
    pred_req = 1'b1; pred_pc = 3'd5;
    #1;
    chk("tr_gnt", 32'(pred_gnt), 32'd1);
    tick;
    chk("tr_taken", 32'(pred_taken), 32'd1);
    chk("tr_index", 32'(pred_index), 32'd5);
    chk("tr_ghr", 32'(ghr_out), 32'b100);
    // pc 1 ^ ghr 100 = 5 again -> taken, history becomes 110.
    pred_pc = 3'd1;
    #1;
    chk("tr2_gnt", 32'(pred_gnt), 32'd1);
    tick;
    chk("tr2_taken", 32'(pred_taken), 32'd1);
    chk("tr2_pghr", 32'(pred_ghr), 32'b100);
    chk("tr2_ghr", 32'(ghr_out), 32'b110);

    // Mispredict in the same cycle as a lookup request.
    pred_pc = 3'd0;
    res_valid = 1'b1; res_mispredict = 1'b1; res_ghr = 3'b011;
    res_taken = 1'b1; res_index = 3'd2;
    #1;
    chk("mp_gnt", 32'(pred_gnt), 32'd0);
    tick;
    pred_req = 1'b0; res_valid = 1'b0; res_mispredict = 1'b0;
    chk("mp_ghr", 32'(ghr_out), 32'b101);
    chk("mp_pvalid", 32'(pred_valid), 32'd0);
    chk("mp_push", 32'(dut.r_count), 32'd1);
    tick; tick; tick;
    chk("mp_pht2", 32'(dut.r_pht[2]), 32'd2);
    chk("mp_drain", 32'(dut.r_count), 32'd0);

    // Full FIFO with lookups held: 5th resolution waits for ready.
    for (int c = 0; c < 8; c++) begin
      pred_req = 1'b1; pred_pc = 3'd0;
      res_valid = 1'b1; res_mispredict = 1'b0;
      res_index = ff_idx[(c < 4) ? c : 4];
      res_taken = ff_tkn[(c < 4) ? c : 4];
      #1;
      chk("ff_gnt", 32'(pred_gnt), 32'(ff_gnt[c]));
      chk("ff_ready", 32'(res_ready), 32'(ff_rdy[c]));
      tick;
    end
    pred_req = 1'b0; res_valid = 1'b0;
    chk("ff_cnt", 32'(dut.r_count), 32'd4);
    for (int w = 0; w < 20 && dut.r_count != 0; w++) tick;
    chk("ff_drain", 32'(dut.r_count), 32'd0);
    chk("ff_pht1", 32'(dut.r_pht[1]), 32'd3);
    chk("ff_pht3", 32'(dut.r_pht[3]), 32'd0);
    chk("ff_pht4", 32'(dut.r_pht[4]), 32'd2);

    // Starvation: one queued update, lookups held high.
    pred_req = 1'b1; pred_pc = 3'd0;
    res_valid = 1'b1; res_index = 3'd6; res_taken = 1'b1;
    #1;
    chk("sv_gnt0", 32'(pred_gnt), 32'd1);
    tick;
    res_valid = 1'b0;
    for (int s = 0; s < 8; s++) begin
      #1;
      chk("sv_gnt", 32'(pred_gnt), 32'(sv_gnt[s]));
      chk("sv_state", 32'(dut.r_state), 32'(sv_st[s]));
      tick;
    end
    pred_req = 1'b0;
    chk("sv_pht6", 32'(dut.r_pht[6]), 32'd2);

    // Reset in the middle of an update.
    res_valid = 1'b1; res_mispredict = 1'b1; res_ghr = 3'b110;
    res_taken = 1'b0; res_index = 3'd0;
    tick;
    res_valid = 1'b0; res_mispredict = 1'b0;
    chk("ru_ghr", 32'(ghr_out), 32'b011);
    pred_req = 1'b1; pred_pc = 3'd6;   // 6 ^ 011 = 5 -> taken
    #1;
    chk("ru_gnt", 32'(pred_gnt), 32'd1);
    tick;
    pred_req = 1'b0;
    chk("ru_pidx", 32'(pred_index), 32'd5);
    tick; tick;
    chk("ru_wr", 32'(dut.r_state), 32'd2);
    chk("ru_preghr", 32'(ghr_out), 32'b101);
    rst_n = 1'b0;
    #1;
    chk("ra_ghr", 32'(ghr_out), 32'd0);
    chk("ra_pvalid", 32'(pred_valid), 32'd0);
    chk("ra_ptaken", 32'(pred_taken), 32'd0);
    chk("ra_pidx", 32'(pred_index), 32'd0);
    chk("ra_pghr", 32'(pred_ghr), 32'd0);
    chk("ra_ready", 32'(res_ready), 32'd1);
    chk("ra_cnt", 32'(dut.r_count), 32'd0);
    chk("ra_state", 32'(dut.r_state), 32'd0);
    for (int i = 0; i < 8; i++) chk("ra_pht", 32'(dut.r_pht[i]), 32'd1);
    tick;
    rst_n = 1'b1;
    tick;
    pred_req = 1'b1; pred_pc = 3'd5;
    #1;
    chk("ra_gnt", 32'(pred_gnt), 32'd1);
    tick;
    pred_req = 1'b0;
    chk("ra_lk_taken", 32'(pred_taken), 32'd0);
    chk("ra_lk_idx", 32'(pred_index), 32'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
